// File: rtl/pcie_wconv_prefetch_fifo_pkg.sv
// Shared width/ratio derivation helpers for the width-converting prefetch FIFO.
// Also provides the parameter-legality predicates that the top module checks at elaboration.
package pcie_wconv_prefetch_fifo_pkg;

  localparam int MAX_RATIO = 64;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  function automatic int wide_width(input int wr_w, input int rd_w);
    return (wr_w > rd_w) ? wr_w : rd_w;
  endfunction

  function automatic int narrow_width(input int wr_w, input int rd_w);
    return (wr_w < rd_w) ? wr_w : rd_w;
  endfunction

  // Lane index registers keep at least one bit, even for a 1:1 ratio.
  function automatic int lane_width(input int ratio);
    return (ratio > 1) ? clog2(ratio) : 1;
  endfunction

  function automatic bit ratio_legal(input int wide, input int narrow);
    int r;
    if (narrow <= 0) return 1'b0;
    if ((wide % narrow) != 0) return 1'b0;
    r = wide / narrow;
    return (r >= 1) && (r <= MAX_RATIO) && ((r & (r - 1)) == 0);
  endfunction

endpackage

// File: rtl/pcie_fifo_mem.sv
// Simple dual-port register-array storage with synchronous write and registered read.
// The read register doubles as the FIFO output stage, so it resets and clears to zero.
module pcie_fifo_mem #(
  parameter int DATA_W = 129,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pcie_wconv_prefetch_fifo.sv
// First-word-fall-through FIFO with write/read width conversion, packet framing, flush and fill level.
// Storage is in wide words; narrow writes are packed and narrow reads are sliced from the output stage.
module pcie_wconv_prefetch_fifo
  import pcie_wconv_prefetch_fifo_pkg::*;
#(
  parameter int WR_DATA_WIDTH = 16,
  parameter int RD_DATA_WIDTH = 128,
  parameter int DEPTH_WIDTH   = 6,
  parameter int AF_THRESH     = 56
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  input  logic                     wr_last,
  output logic                     wr_vld,
  input  logic                     rd_en,
  output logic [RD_DATA_WIDTH-1:0] rd_data,
  output logic                     rd_last,
  output logic                     rd_vld,
  output logic [DEPTH_WIDTH:0]     level,
  output logic                     almost_full
);

  localparam int WIDE_W   = wide_width(WR_DATA_WIDTH, RD_DATA_WIDTH);
  localparam int NARROW_W = narrow_width(WR_DATA_WIDTH, RD_DATA_WIDTH);
  localparam int WR_LANES = WIDE_W / WR_DATA_WIDTH;
  localparam int RD_LANES = WIDE_W / RD_DATA_WIDTH;
  localparam int WL_W     = lane_width(WR_LANES);
  localparam int RL_W     = lane_width(RD_LANES);
  localparam int CAP      = 2 ** DEPTH_WIDTH;
  localparam int LVL_W    = DEPTH_WIDTH + 1;

  localparam logic [WL_W-1:0]  WR_LANE_MAX = WL_W'(WR_LANES - 1);
  localparam logic [RL_W-1:0]  RD_LANE_MAX = RL_W'(RD_LANES - 1);
  localparam logic [LVL_W-1:0] LVL_CAP     = LVL_W'(CAP);
  localparam logic [LVL_W-1:0] LVL_AF      = LVL_W'(AF_THRESH);

  generate
    if (!ratio_legal(WIDE_W, NARROW_W)) begin : g_bad_ratio
      $error("pcie_wconv_prefetch_fifo: WR/RD width ratio must be a power of 2 in 1..64");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > CAP)) begin : g_bad_af
      $error("pcie_wconv_prefetch_fifo: AF_THRESH must be in 1..2**DEPTH_WIDTH");
    end
  endgenerate

  logic [WIDE_W-1:0] pack_q;
  logic [WIDE_W-1:0] commit_word;
  logic [WL_W-1:0]   wr_lane_q;
  logic [RL_W-1:0]   rd_lane_q;
  logic [LVL_W-1:0]  wptr_q;
  logic [LVL_W-1:0]  rptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              out_vld_q;
  logic [WIDE_W:0]   out_q;

  logic full;
  logic commit_pend;
  logic wr_fire;
  logic commit;
  logic pop;
  logic free;
  logic mem_ne;
  logic load;

  // A word in flight to the output stage still counts toward level, so full is judged on level alone.
  assign full        = (level_q == LVL_CAP);
  assign commit_pend = (wr_lane_q == WR_LANE_MAX) || wr_last;
  assign wr_vld      = !(full && commit_pend);
  assign wr_fire     = wr_en && wr_vld && !flush;
  assign commit      = wr_fire && commit_pend;
  assign pop         = rd_en && out_vld_q && !flush;
  assign free        = pop && (rd_lane_q == RD_LANE_MAX);
  assign mem_ne      = (wptr_q != rptr_q);
  assign load        = mem_ne && (!out_vld_q || free) && !flush;

  always_comb begin
    commit_word = pack_q;
    commit_word[wr_lane_q*WR_DATA_WIDTH +: WR_DATA_WIDTH] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q    <= '0;
      wr_lane_q <= '0;
      rd_lane_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      out_vld_q <= 1'b0;
    end else if (flush) begin
      pack_q    <= '0;
      wr_lane_q <= '0;
      rd_lane_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      out_vld_q <= 1'b0;
    end else begin
      // Clearing the pack register on commit keeps unfilled lanes of short packets at zero.
      if (wr_fire) begin
        if (commit) begin
          pack_q    <= '0;
          wr_lane_q <= '0;
        end else begin
          pack_q    <= commit_word;
          wr_lane_q <= wr_lane_q + 1'b1;
        end
      end
      if (commit) wptr_q <= wptr_q + 1'b1;
      if (load)   rptr_q <= rptr_q + 1'b1;
      if (pop)    rd_lane_q <= free ? '0 : rd_lane_q + 1'b1;
      if (load) begin
        out_vld_q <= 1'b1;
      end else if (free) begin
        out_vld_q <= 1'b0;
      end
      level_q <= level_q + LVL_W'(commit) - LVL_W'(free);
    end
  end

  pcie_fifo_mem #(
    .DATA_W (WIDE_W + 1),
    .ADDR_W (DEPTH_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .wr_en   (commit),
    .wr_addr (wptr_q[DEPTH_WIDTH-1:0]),
    .wr_data ({wr_last, commit_word}),
    .rd_en   (load),
    .rd_addr (rptr_q[DEPTH_WIDTH-1:0]),
    .rd_data (out_q)
  );

  assign rd_vld      = out_vld_q;
  assign rd_data     = out_q[rd_lane_q*RD_DATA_WIDTH +: RD_DATA_WIDTH];
  assign rd_last     = out_vld_q && out_q[WIDE_W] && (rd_lane_q == RD_LANE_MAX);
  assign level       = level_q;
  assign almost_full = (level_q >= LVL_AF);

endmodule

// File: tb/tb_pcie_wconv_prefetch_fifo.sv
// Scoreboard bench for the width-converting FIFO: upsize 16->128, downsize 128->32 and 1:1 16/16 depth 4.
// Stimulus pushes expected read words into per-instance queues; monitors pop and compare on every fired read.
module tb_pcie_wconv_prefetch_fifo;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } sb_t;

  logic clk;
  logic rst_n;

  logic         flush_up, wr_en_up, wr_last_up, wr_vld_up, rd_en_up, rd_last_up, rd_vld_up, af_up;
  logic [15:0]  wr_data_up;
  logic [127:0] rd_data_up;
  logic [6:0]   level_up;

  logic         flush_dn, wr_en_dn, wr_last_dn, wr_vld_dn, rd_en_dn, rd_last_dn, rd_vld_dn, af_dn;
  logic [127:0] wr_data_dn;
  logic [31:0]  rd_data_dn;
  logic [6:0]   level_dn;

  logic         flush_11, wr_en_11, wr_last_11, wr_vld_11, rd_en_11, rd_last_11, rd_vld_11, af_11;
  logic [15:0]  wr_data_11;
  logic [15:0]  rd_data_11;
  logic [2:0]   level_11;

  sb_t q_up[$];
  sb_t q_dn[$];
  sb_t q_11[$];

  int n_tests = 0;
  int n_fail  = 0;

  pcie_wconv_prefetch_fifo #(.WR_DATA_WIDTH(16), .RD_DATA_WIDTH(128), .DEPTH_WIDTH(6), .AF_THRESH(56)) u_up (
    .clk(clk), .rst_n(rst_n), .flush(flush_up), .wr_en(wr_en_up), .wr_data(wr_data_up),
    .wr_last(wr_last_up), .wr_vld(wr_vld_up), .rd_en(rd_en_up), .rd_data(rd_data_up),
    .rd_last(rd_last_up), .rd_vld(rd_vld_up), .level(level_up), .almost_full(af_up));

  pcie_wconv_prefetch_fifo #(.WR_DATA_WIDTH(128), .RD_DATA_WIDTH(32), .DEPTH_WIDTH(6), .AF_THRESH(56)) u_dn (
    .clk(clk), .rst_n(rst_n), .flush(flush_dn), .wr_en(wr_en_dn), .wr_data(wr_data_dn),
    .wr_last(wr_last_dn), .wr_vld(wr_vld_dn), .rd_en(rd_en_dn), .rd_data(rd_data_dn),
    .rd_last(rd_last_dn), .rd_vld(rd_vld_dn), .level(level_dn), .almost_full(af_dn));

  pcie_wconv_prefetch_fifo #(.WR_DATA_WIDTH(16), .RD_DATA_WIDTH(16), .DEPTH_WIDTH(2), .AF_THRESH(3)) u_11 (
    .clk(clk), .rst_n(rst_n), .flush(flush_11), .wr_en(wr_en_11), .wr_data(wr_data_11),
    .wr_last(wr_last_11), .wr_vld(wr_vld_11), .rd_en(rd_en_11), .rd_data(rd_data_11),
    .rd_last(rd_last_11), .rd_vld(rd_vld_11), .level(level_11), .almost_full(af_11));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: rd_vld stayed 0, required 1 within 20 cycles", name);
  endtask

  // Monitors: compare on every read that fires at the coming rising edge.
  always @(negedge clk) begin : mon_up
    sb_t e;
    if (rst_n && !flush_up && rd_en_up && rd_vld_up) begin
      if (q_up.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL up_pop: unexpected word %0h", rd_data_up);
      end else begin
        e = q_up.pop_front();
        check("up_data", rd_data_up, e.data);
        check("up_last", 128'(rd_last_up), 128'(e.last));
      end
    end
  end

  always @(negedge clk) begin : mon_dn
    sb_t e;
    if (rst_n && !flush_dn && rd_en_dn && rd_vld_dn) begin
      if (q_dn.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dn_pop: unexpected word %0h", rd_data_dn);
      end else begin
        e = q_dn.pop_front();
        check("dn_data", 128'(rd_data_dn), e.data);
        check("dn_last", 128'(rd_last_dn), 128'(e.last));
      end
    end
  end

  always @(negedge clk) begin : mon_11
    sb_t e;
    if (rst_n && !flush_11 && rd_en_11 && rd_vld_11) begin
      if (q_11.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL w11_pop: unexpected word %0h", rd_data_11);
      end else begin
        e = q_11.pop_front();
        check("w11_data", 128'(rd_data_11), e.data);
        check("w11_last", 128'(rd_last_11), 128'(e.last));
      end
    end
  end

  function automatic sb_t mk(input logic [127:0] d, input logic l);
    sb_t e;
    e.data = d;
    e.last = l;
    return e;
  endfunction

  task automatic up_write(input logic [15:0] d, input logic l);
    wr_en_up = 1'b1; wr_data_up = d; wr_last_up = l;
    @(posedge clk); #1;
    wr_en_up = 1'b0; wr_last_up = 1'b0;
  endtask

  task automatic dn_write(input logic [127:0] d, input logic l);
    wr_en_dn = 1'b1; wr_data_dn = d; wr_last_dn = l;
    @(posedge clk); #1;
    wr_en_dn = 1'b0; wr_last_dn = 1'b0;
  endtask

  task automatic w11_write(input logic [15:0] d, input logic l);
    wr_en_11 = 1'b1; wr_data_11 = d; wr_last_11 = l;
    @(posedge clk); #1;
    wr_en_11 = 1'b0; wr_last_11 = 1'b0;
  endtask

  task automatic up_pop();
    int n = 0;
    while (!rd_vld_up && n < 20) begin @(posedge clk); #1; n++; end
    if (!rd_vld_up) begin timeout_fail("up_wait"); return; end
    rd_en_up = 1'b1;
    @(posedge clk); #1;
    rd_en_up = 1'b0;
  endtask

  task automatic dn_pop();
    int n = 0;
    while (!rd_vld_dn && n < 20) begin @(posedge clk); #1; n++; end
    if (!rd_vld_dn) begin timeout_fail("dn_wait"); return; end
    rd_en_dn = 1'b1;
    @(posedge clk); #1;
    rd_en_dn = 1'b0;
  endtask

  task automatic w11_pop();
    int n = 0;
    while (!rd_vld_11 && n < 20) begin @(posedge clk); #1; n++; end
    if (!rd_vld_11) begin timeout_fail("w11_wait"); return; end
    rd_en_11 = 1'b1;
    @(posedge clk); #1;
    rd_en_11 = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [15:0]  seq_a [4];
    logic [127:0] words [4];

    rst_n = 1'b0;
    flush_up = 0; wr_en_up = 0; wr_last_up = 0; rd_en_up = 0; wr_data_up = '0;
    flush_dn = 0; wr_en_dn = 0; wr_last_dn = 0; rd_en_dn = 0; wr_data_dn = '0;
    flush_11 = 0; wr_en_11 = 0; wr_last_11 = 0; rd_en_11 = 0; wr_data_11 = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_up_rd_vld", 128'(rd_vld_up), 0);
    check("rst_up_level", 128'(level_up), 0);
    check("rst_up_wr_vld", 128'(wr_vld_up), 1);
    check("rst_up_rd_data", rd_data_up, 0);
    check("rst_up_af", 128'(af_up), 0);
    check("rst_dn_rd_last", 128'(rd_last_dn), 0);
    check("rst_11_wr_vld", 128'(wr_vld_11), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: full 8-lane upsize word, latency check
    q_up.push_back(mk(128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b0));
    for (int i = 1; i <= 8; i++) up_write(16'(i), 1'b0);
    check("t1_rd_vld_after_commit", 128'(rd_vld_up), 0);
    check("t1_level_after_commit", 128'(level_up), 1);
    @(posedge clk); #1;
    check("t1_rd_vld_next_edge", 128'(rd_vld_up), 1);
    check("t1_rd_last", 128'(rd_last_up), 0);
    up_pop();
    check("t1_rd_vld_after_pop", 128'(rd_vld_up), 0);
    check("t1_level_after_pop", 128'(level_up), 0);

    // 2: short packet, upper lanes zero-filled
    q_up.push_back(mk(128'h000C_000B_000A, 1'b1));
    up_write(16'h000A, 1'b0);
    up_write(16'h000B, 1'b0);
    up_write(16'h000C, 1'b1);
    up_pop();
    check("t2_level", 128'(level_up), 0);

    // 5: flush mid-pack, write presented during flush is discarded
    for (int i = 1; i <= 5; i++) up_write(16'(i), 1'b0);
    flush_up = 1'b1; wr_en_up = 1'b1; wr_data_up = 16'h00FF;
    @(posedge clk); #1;
    flush_up = 1'b0; wr_en_up = 1'b0;
    check("t5_rd_vld", 128'(rd_vld_up), 0);
    check("t5_level", 128'(level_up), 0);
    check("t5_wr_vld", 128'(wr_vld_up), 1);
    q_up.push_back(mk(128'h0017_0016_0015_0014_0013_0012_0011_0010, 1'b0));
    for (int i = 0; i < 8; i++) up_write(16'h0010 + 16'(i), 1'b0);
    up_pop();

    // 3: downsize 128->32
    q_dn.push_back(mk(128'h1111_1111, 1'b0));
    q_dn.push_back(mk(128'h2222_2222, 1'b0));
    q_dn.push_back(mk(128'h3333_3333, 1'b0));
    q_dn.push_back(mk(128'h4444_4444, 1'b1));
    dn_write(128'h44444444_33333333_22222222_11111111, 1'b1);
    for (int i = 0; i < 3; i++) dn_pop();
    check("t3_level_before_last", 128'(level_dn), 1);
    check("t3_rd_last_lane3", 128'(rd_last_dn), 1);
    dn_pop();
    check("t3_level_after_last", 128'(level_dn), 0);
    check("t3_rd_vld_after_last", 128'(rd_vld_dn), 0);

    // 4: 1:1 depth 4, full, simultaneous write+pop, almost_full
    seq_a[0] = 16'h1111; seq_a[1] = 16'h2222; seq_a[2] = 16'h3333; seq_a[3] = 16'h4444;
    for (int i = 0; i < 4; i++) begin
      q_11.push_back(mk(128'(seq_a[i]), i == 3));
      w11_write(seq_a[i], i == 3);
      check("t4_level_fill", 128'(level_11), 128'(i + 1));
      check("t4_af_fill", 128'(af_11), 128'(i >= 2));
    end
    check("t4_wr_vld_full", 128'(wr_vld_11), 0);
    wr_en_11 = 1'b1; wr_data_11 = 16'h5555; rd_en_11 = 1'b1;
    @(posedge clk); #1;
    wr_en_11 = 1'b0; rd_en_11 = 1'b0;
    check("t4_level_pop_only", 128'(level_11), 3);
    check("t4_wr_vld_reassert", 128'(wr_vld_11), 1);
    check("t4_af_at_3", 128'(af_11), 1);
    rd_en_11 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t4_b2b_rd_vld", 128'(rd_vld_11), 1);
      @(posedge clk); #1;
    end
    rd_en_11 = 1'b0;
    check("t4_empty_rd_vld", 128'(rd_vld_11), 0);
    check("t4_empty_level", 128'(level_11), 0);
    check("t4_empty_af", 128'(af_11), 0);

    // 6: reset mid-word on downsize
    q_dn.push_back(mk(128'hAAAA_AAAA, 1'b0));
    dn_write(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b1);
    dn_pop();
    rst_n = 1'b0;
    #1;
    check("t6_rst_rd_vld", 128'(rd_vld_dn), 0);
    check("t6_rst_level", 128'(level_dn), 0);
    check("t6_rst_wr_vld", 128'(wr_vld_dn), 1);
    check("t6_rst_rd_last", 128'(rd_last_dn), 0);
    check("t6_rst_rd_data", 128'(rd_data_dn), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    words[0] = 128'h5555_5555; words[1] = 128'h6666_6666;
    words[2] = 128'h7777_7777; words[3] = 128'h8888_8888;
    for (int i = 0; i < 4; i++) q_dn.push_back(mk(words[i], i == 3));
    dn_write(128'h88888888_77777777_66666666_55555555, 1'b1);
    for (int i = 0; i < 4; i++) dn_pop();
    check("t6_level_end", 128'(level_dn), 0);

    repeat (2) @(posedge clk);
    #1;
    check("q_up_drained", 128'(q_up.size()), 0);
    check("q_dn_drained", 128'(q_dn.size()), 0);
    check("q_11_drained", 128'(q_11.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
